// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - field positions, opcodes, FSM states and packing helpers for inst_encoder
package inst_encoder_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int REG_W       = 32;
  localparam int INST_W      = 64;

  localparam logic [3:0] MEM_SREG = 4'h1;
  localparam logic [3:0] MEM_DREG = 4'h2;

  localparam logic [7:0] EXE_AND = 8'h24;
  localparam logic [7:0] EXE_OR  = 8'h25;
  localparam logic [7:0] EXE_XOR = 8'h26;
  localparam logic [7:0] EXE_NOT = 8'h27;

  localparam int INST_MEM_HI  = 63;
  localparam int INST_MEM_LO  = 60;
  localparam int INST_OP_HI   = 59;
  localparam int INST_OP_LO   = 52;
  localparam int INST_WD_HI   = 51;
  localparam int INST_WD_LO   = 47;
  localparam int INST_RS1_HI  = 46;
  localparam int INST_RS1_LO  = 42;
  localparam int INST_RS2_HI  = 41;
  localparam int INST_RS2_LO  = 37;
  localparam int INST_IMM_HI  = 41;
  localparam int INST_IMM_LO  = 10;
  localparam int INST_NIMM_HI = 46;
  localparam int INST_NIMM_LO = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } enc_state_e;

  // Anything that is not DREG is packed with the SREG layout, so raw words stay decodable.
  function automatic logic [INST_W-1:0] encode_word(
    input logic [3:0]            mem,
    input logic [7:0]            op,
    input logic [REG_ADDR_W-1:0] wd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic [REG_W-1:0]      imm
  );
    logic [INST_W-1:0] w;
    w = '0;
    w[INST_MEM_HI:INST_MEM_LO] = mem;
    w[INST_OP_HI:INST_OP_LO]   = op;
    w[INST_WD_HI:INST_WD_LO]   = wd;
    if (mem == MEM_DREG) begin
      w[INST_RS1_HI:INST_RS1_LO] = rs1;
      w[INST_RS2_HI:INST_RS2_LO] = rs2;
    end else if (op == EXE_NOT) begin
      w[INST_NIMM_HI:INST_NIMM_LO] = imm[30:0];
    end else begin
      w[INST_RS1_HI:INST_RS1_LO] = rs1;
      w[INST_IMM_HI:INST_IMM_LO] = imm;
    end
    return w;
  endfunction

  function automatic logic is_legal(input logic [3:0] mem, input logic [7:0] op);
    logic mem_ok;
    logic op_ok;
    mem_ok = (mem == MEM_SREG) || (mem == MEM_DREG);
    op_ok  = (op == EXE_OR) || (op == EXE_AND) || (op == EXE_XOR) || (op == EXE_NOT);
    return mem_ok && op_ok;
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// rtl/inst_enc_fifo.sv - synchronous DEPTH x WIDTH word FIFO with full/empty flags
module inst_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs field requests into 64-bit words and streams them into instruction ROM
// Optional illegal-request filtering via INST_ENC_ILLEGAL_CHECK_EN.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_STEP = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [INST_ADDR_W-1:0] base_addr_i,
  input  logic                   end_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [3:0]             req_mem_i,
  input  logic [7:0]             req_op_i,
  input  logic [REG_ADDR_W-1:0]  req_wd_i,
  input  logic [REG_ADDR_W-1:0]  req_rs1_i,
  input  logic [REG_ADDR_W-1:0]  req_rs2_i,
  input  logic [REG_W-1:0]       req_imm_i,
  output logic                   rom_we_o,
  input  logic                   rom_ready_i,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [15:0]            wr_cnt_o
);

  enc_state_e             state_q, state_d;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [INST_W-1:0] fifo_head, enc_word;
  logic              accept, legal;

  assign enc_word = encode_word(req_mem_i, req_op_i, req_wd_i, req_rs1_i, req_rs2_i, req_imm_i);

`ifdef INST_ENC_ILLEGAL_CHECK_EN
  assign legal = is_legal(req_mem_i, req_op_i);
`else
  assign legal = 1'b1;
`endif

  assign req_ready_o = (state_q == ST_RUN) && !fifo_full;
  assign accept      = req_valid_i && req_ready_o;
  assign fifo_push   = accept && legal;
  assign rom_we_o    = !fifo_empty && (state_q != ST_IDLE);
  assign fifo_pop    = rom_we_o && rom_ready_i;

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (enc_word),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          addr_d  = base_addr_i;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (end_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) begin
      addr_d = addr_q + INST_ADDR_W'(ADDR_STEP);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
`ifdef INST_ENC_ILLEGAL_CHECK_EN
    if (accept && !legal) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Head entry is masked so the data bus reads zero whenever no write is offered.
  assign rom_data_o = rom_we_o ? fifo_head : '0;
  assign rom_addr_o = addr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DRAIN) && fifo_empty;
  assign err_o      = err_q;
  assign wr_cnt_o   = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder with a field-arithmetic reference model
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic        end_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_mem_i = '0;
  logic [7:0]  req_op_i = '0;
  logic [4:0]  req_wd_i = '0;
  logic [4:0]  req_rs1_i = '0;
  logic [4:0]  req_rs2_i = '0;
  logic [31:0] req_imm_i = '0;
  logic        rom_we_o;
  logic        rom_ready_i = 1'b1;
  logic [31:0] rom_addr_o;
  logic [63:0] rom_data_o;
  logic        busy_o, done_o, err_o;
  logic [15:0] wr_cnt_o;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .ADDR_STEP(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i), .end_i(end_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mem_i(req_mem_i),
    .req_op_i(req_op_i), .req_wd_i(req_wd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_imm_i(req_imm_i), .rom_we_o(rom_we_o), .rom_ready_i(rom_ready_i),
    .rom_addr_o(rom_addr_o), .rom_data_o(rom_data_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .wr_cnt_o(wr_cnt_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_done = 0;
  int          n_acc  = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_addr = '0;
  bit          ready_rand = 1'b0;
  bit          ready_force = 1'b1;

  always @(posedge clk) begin
    #1 rom_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packing: place each field by its bit offset with shifts and ORs.
  function automatic logic [63:0] model_word(input logic [3:0] mem, input logic [7:0] op,
                                              input logic [4:0] wd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [31:0] imm);
    logic [63:0] w;
    w = (64'(mem) << 60) | (64'(op) << 52) | (64'(wd) << 47);
    if (mem == MEM_DREG)      w = w | (64'(rs1) << 42) | (64'(rs2) << 37);
    else if (op == EXE_NOT)   w = w | ((64'(imm) & 64'h7FFF_FFFF) << 16);
    else                      w = w | (64'(rs1) << 42) | (64'(imm) << 10);
    return w;
  endfunction

  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst && done_o) n_done++;
    if (rst && rom_we_o && rom_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", rom_addr_o, rom_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(rom_addr_o), 64'(e.addr));
        chk("wr_data", rom_data_o, e.data);
      end
    end
  end

  task automatic start_session(input logic [31:0] base);
    start_i = 1'b1;
    base_addr_i = base;
    @(posedge clk); #1;
    start_i = 1'b0;
    exp_addr = base;
    exp_cnt = 0;
  endtask

  task automatic send(input logic [3:0] mem, input logic [7:0] op, input logic [4:0] wd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input bit pushes, input bit use_exp, input logic [63:0] exp_data);
    bit acc;
    logic [63:0] d;
    acc = 1'b0;
    req_mem_i = mem; req_op_i = op; req_wd_i = wd;
    req_rs1_i = rs1; req_rs2_i = rs2; req_imm_i = imm;
    req_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = 1'b1;
        n_acc++;
        if (pushes) begin
          d = use_exp ? exp_data : model_word(mem, op, wd, rs1, rs2, imm);
          exp_q.push_back('{addr: exp_addr, data: d});
          exp_addr = exp_addr + 32'd8;
          exp_cnt++;
        end
        @(posedge clk); #1;
        break;
      end
    end
    req_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic end_session();
    end_i = 1'b1;
    @(posedge clk); #1;
    end_i = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("wr_cnt", 64'(wr_cnt_o), 64'(exp_cnt));
    chk("err", 64'(err_o), 64'(exp_err));
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int acc0;
    int d0;
    logic [3:0] m;
    logic [7:0] ops[4];
    bit exp_err_ill;
    ops[0] = EXE_OR; ops[1] = EXE_AND; ops[2] = EXE_XOR; ops[3] = EXE_NOT;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_we", 64'(rom_we_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_cnt", 64'(wr_cnt_o), 64'd0);
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_addr", 64'(rom_addr_o), 64'd0);
    chk("rst_data", rom_data_o, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic single SREG OR word
    start_session(32'h100);
    send(MEM_SREG, EXE_OR, 5'd3, 5'd1, 5'd0, 32'hFF, 1'b1, 1'b1,
         {MEM_SREG, EXE_OR, 5'd3, 5'd1, 32'hFF, 10'd0});
    end_session();
    wait_done(1'b0);

    // DREG and SREG NOT layouts
    start_session(32'h180);
    send(MEM_DREG, EXE_AND, 5'd7, 5'd2, 5'd4, 32'h1234_5678, 1'b1, 1'b1,
         {MEM_DREG, EXE_AND, 5'd7, 5'd2, 5'd4, 37'd0});
    send(MEM_SREG, EXE_NOT, 5'd9, 5'd1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b1,
         {MEM_SREG, EXE_NOT, 5'd9, 31'h7FFF_FFFF, 16'd0});
    end_session();
    wait_done(1'b0);

    // Backpressure: ROM stalled while six requests are offered
    ready_force = 1'b0;
    @(posedge clk); #1;
    start_session(32'h100);
    acc0 = n_acc;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(MEM_SREG, EXE_XOR, 5'(k), 5'(k + 1), 5'd0, 32'(k * 3 + 1), 1'b1, 1'b0, 64'd0);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (rom_we_o) begin
            chk("hold_addr", 64'(rom_addr_o), 64'h100);
            if (exp_q.size() > 0) chk("hold_data", rom_data_o, exp_q[0].data);
          end
        end
        chk("bp_accepts", 64'(n_acc - acc0), 64'(DEPTH));
        chk("bp_ready_low", 64'(req_ready_o), 64'd0);
        ready_force = 1'b1;
      end
    join
    end_session();
    wait_done(1'b0);

    // Address wrap past all-ones
    start_session(32'hFFFF_FFF8);
    send(MEM_SREG, EXE_AND, 5'd1, 5'd2, 5'd0, 32'hA5A5_0001, 1'b1, 1'b0, 64'd0);
    send(MEM_DREG, EXE_OR, 5'd5, 5'd6, 5'd7, 32'h0, 1'b1, 1'b0, 64'd0);
    end_session();
    wait_done(1'b0);

    // Illegal class followed by a legal word
`ifdef INST_ENC_ILLEGAL_CHECK_EN
    exp_err_ill = 1'b1;
`else
    exp_err_ill = 1'b0;
`endif
    start_session(32'h200);
    send(4'hF, EXE_OR, 5'd2, 5'd3, 5'd4, 32'hDEAD_BEEF, !exp_err_ill, 1'b0, 64'd0);
    send(MEM_SREG, EXE_OR, 5'd4, 5'd5, 5'd0, 32'h55, 1'b1, 1'b0, 64'd0);
    end_session();
    wait_done(exp_err_ill);

    // Randomized session with random ROM backpressure
    ready_rand = 1'b1;
    start_session({$urandom_range(0, 32'h1FFF_FFFF), 3'b000});
    for (int k = 0; k < 24; k++) begin
      m = ($urandom_range(0, 1) == 0) ? MEM_SREG : MEM_DREG;
      send(m, ops[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
           1'b1, 1'b0, 64'd0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    end_session();
    ready_rand = 1'b0;
    ready_force = 1'b1;
    wait_done(1'b0);

    // Reset in the middle of DRAIN with words still queued
    ready_force = 1'b0;
    @(posedge clk); #1;
    start_session(32'h300);
    for (int k = 0; k < 3; k++)
      send(MEM_DREG, EXE_XOR, 5'(k), 5'(k), 5'(k), 32'h0, 1'b1, 1'b0, 64'd0);
    end_session();
    chk("drain_busy", 64'(busy_o), 64'd1);
    chk("drain_we", 64'(rom_we_o), 64'd1);
    d0 = n_done;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_we", 64'(rom_we_o), 64'd0);
    chk("mid_rst_cnt", 64'(wr_cnt_o), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);
    exp_q.delete();
    rst = 1'b1;
    ready_force = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_rst", 64'(n_done), 64'(d0));
    chk("idle_after_rst", 64'(busy_o), 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
